// File: rtl/ir_prefetch_queue.sv
// Instruction register fronted by a small prefetch FIFO.
// Instruction memory pushes {PC, instruction} pairs under a valid/ready
// handshake. IRWre moves the head entry into the decode register, which is
// then presented as MIPS fields.
// Optional feature macro: IR_EXT_IMM_EN adds ExtSel and a registered,
// sign- or zero-extended immediate on Ext_Imm.
module ir_prefetch_queue #(
    parameter  int DEPTH = 4,
    parameter  int PC_W  = 32,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             Flush,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [31:0]      Ins_Data,
    input  logic [PC_W-1:0]  Ins_PC,
    input  logic             IRWre,
    output logic [5:0]       Op_code,
    output logic [4:0]       Rs_reg,
    output logic [4:0]       Rt_reg,
    output logic [4:0]       Rd_reg,
    output logic [4:0]       Sa_number,
    output logic [15:0]      Imm_number,
    output logic [PC_W-1:0]  IR_PC,
    output logic             IR_Valid,
    output logic [CNT_W-1:0] Count
`ifdef IR_EXT_IMM_EN
    ,
    input  logic             ExtSel,
    output logic [31:0]      Ext_Imm
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = PC_W + 32;

    // Pointers carry one extra wrap bit so that full and empty are distinct
    // and occupancy is a plain subtraction.
    logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]      ir_q, ir_d;
    logic [PC_W-1:0]  ir_pc_q, ir_pc_d;
    logic             ir_valid_q, ir_valid_d;
    logic [EW-1:0]    mem_q [DEPTH];

    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic [EW-1:0]    head;

`ifdef IR_EXT_IMM_EN
    logic [31:0] ext_imm_q, ext_imm_d;
`endif

    // Occupancy, handshake and transfer qualification.
    always_comb begin
        count    = wr_ptr_q - rd_ptr_q;
        In_Ready = (count < CNT_W'(DEPTH));
        push     = In_Valid & In_Ready & ~Flush;
        pop      = IRWre & (count != '0) & ~Flush;
        head     = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Next-state for pointers and the decode register; Flush dominates.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
`ifdef IR_EXT_IMM_EN
        ext_imm_d  = ext_imm_q;
`endif
        if (Flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            ir_valid_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr_d   = rd_ptr_q + CNT_W'(1);
                ir_d       = head[31:0];
                ir_pc_d    = head[EW-1:32];
                ir_valid_d = 1'b1;
`ifdef IR_EXT_IMM_EN
                ext_imm_d  = ExtSel ? {{16{head[15]}}, head[15:0]}
                                    : {16'h0000, head[15:0]};
`endif
            end else if (IRWre) begin
                // Starved decode: mark IR stale but keep the last fields.
                ir_valid_d = 1'b0;
            end
        end
    end

    // Control and decode registers, asynchronously cleared.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
`ifdef IR_EXT_IMM_EN
            ext_imm_q  <= '0;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
`ifdef IR_EXT_IMM_EN
            ext_imm_q  <= ext_imm_d;
`endif
        end
    end

    // FIFO storage has no reset; pointers alone define which entries are live.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {Ins_PC, Ins_Data};
        end
    end

    // Field slices of the registered IR; Imm_number overlaps Rd/Sa on purpose.
    always_comb begin
        Op_code    = ir_q[31:26];
        Rs_reg     = ir_q[25:21];
        Rt_reg     = ir_q[20:16];
        Rd_reg     = ir_q[15:11];
        Sa_number  = ir_q[10:6];
        Imm_number = ir_q[15:0];
        IR_PC      = ir_pc_q;
        IR_Valid   = ir_valid_q;
        Count      = count;
`ifdef IR_EXT_IMM_EN
        Ext_Imm    = ext_imm_q;
`endif
    end

endmodule

// File: tb/tb_ir_prefetch_queue.sv
// Self-checking bench for ir_prefetch_queue. A queue-based reference model
// tracks FIFO contents and the decode register; directed scenarios are
// followed by a randomized run.
module tb_ir_prefetch_queue;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             CLK = 1'b0;
    logic             RST_n;
    logic             Flush;
    logic             In_Valid;
    logic             In_Ready;
    logic [31:0]      Ins_Data;
    logic [PC_W-1:0]  Ins_PC;
    logic             IRWre;
    logic [5:0]       Op_code;
    logic [4:0]       Rs_reg;
    logic [4:0]       Rt_reg;
    logic [4:0]       Rd_reg;
    logic [4:0]       Sa_number;
    logic [15:0]      Imm_number;
    logic [PC_W-1:0]  IR_PC;
    logic             IR_Valid;
    logic [CNT_W-1:0] Count;
`ifdef IR_EXT_IMM_EN
    logic             ExtSel;
    logic [31:0]      Ext_Imm;
`endif

    ir_prefetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .Flush      (Flush),
        .In_Valid   (In_Valid),
        .In_Ready   (In_Ready),
        .Ins_Data   (Ins_Data),
        .Ins_PC     (Ins_PC),
        .IRWre      (IRWre),
        .Op_code    (Op_code),
        .Rs_reg     (Rs_reg),
        .Rt_reg     (Rt_reg),
        .Rd_reg     (Rd_reg),
        .Sa_number  (Sa_number),
        .Imm_number (Imm_number),
        .IR_PC      (IR_PC),
        .IR_Valid   (IR_Valid),
        .Count      (Count)
`ifdef IR_EXT_IMM_EN
        ,
        .ExtSel     (ExtSel),
        .Ext_Imm    (Ext_Imm)
`endif
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [63:0] q_m [$];
    logic [31:0] ir_m;
    logic [31:0] pc_m;
    logic        valid_m;
    logic [31:0] ext_m;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_m.delete();
        ir_m    = '0;
        pc_m    = '0;
        valid_m = 1'b0;
        ext_m   = '0;
    endtask

    // One clock with the currently driven inputs; model and DUT compared
    // just before and just after the edge.
    task automatic step();
        logic        room;
        logic [63:0] head;
        room = (q_m.size() < DEPTH);
        chk("in_ready", 64'(In_Ready), 64'(room));
        chk("count_pre", 64'(Count), 64'(q_m.size()));
        if (Flush) begin
            q_m.delete();
            valid_m = 1'b0;
        end else begin
            if (IRWre) begin
                if (q_m.size() > 0) begin
                    head    = q_m.pop_front();
                    ir_m    = head[31:0];
                    pc_m    = head[63:32];
                    valid_m = 1'b1;
`ifdef IR_EXT_IMM_EN
                    ext_m   = ExtSel ? 32'($signed(head[15:0])) : {16'h0, head[15:0]};
`endif
                end else begin
                    valid_m = 1'b0;
                end
            end
            if (In_Valid && room) q_m.push_back({Ins_PC, Ins_Data});
        end
        @(posedge CLK);
        #1;
        chk("op_code",  64'(Op_code),    64'(ir_m[31:26]));
        chk("rs_reg",   64'(Rs_reg),     64'(ir_m[25:21]));
        chk("rt_reg",   64'(Rt_reg),     64'(ir_m[20:16]));
        chk("rd_reg",   64'(Rd_reg),     64'(ir_m[15:11]));
        chk("sa",       64'(Sa_number),  64'(ir_m[10:6]));
        chk("imm",      64'(Imm_number), 64'(ir_m[15:0]));
        chk("ir_pc",    64'(IR_PC),      64'(pc_m));
        chk("ir_valid", 64'(IR_Valid),   64'(valid_m));
        chk("count",    64'(Count),      64'(q_m.size()));
`ifdef IR_EXT_IMM_EN
        chk("ext_imm",  64'(Ext_Imm),    64'(ext_m));
`endif
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [31:0] pc,
                         input logic wre, input logic fl);
        In_Valid = v;
        Ins_Data = d;
        Ins_PC   = pc;
        IRWre    = wre;
        Flush    = fl;
    endtask

    initial begin
        RST_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
`ifdef IR_EXT_IMM_EN
        ExtSel = 1'b0;
`endif
        model_reset();
        repeat (2) @(posedge CLK);
        #3 RST_n = 1'b1;
        @(posedge CLK);
        #1;
        chk("rst_count", 64'(Count), 64'd0);
        chk("rst_ready", 64'(In_Ready), 64'd1);
        chk("rst_valid", 64'(IR_Valid), 64'd0);

        // Decode: push one word, load it on the next cycle.
        drive(1'b1, 32'h8C22_1234, 32'h10, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        chk("dec_op", 64'(Op_code), 64'h23);
        chk("dec_rs", 64'(Rs_reg), 64'd1);
        chk("dec_rt", 64'(Rt_reg), 64'd2);
        chk("dec_rd", 64'(Rd_reg), 64'd2);
        chk("dec_sa", 64'(Sa_number), 64'd8);
        chk("dec_imm", 64'(Imm_number), 64'h1234);
        chk("dec_pc", 64'(IR_PC), 64'h10);
        chk("dec_valid", 64'(IR_Valid), 64'd1);
        chk("dec_count", 64'(Count), 64'd0);

        // Full: five back-to-back offers, only four taken.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h100 + 32'(i), 32'h200 + 32'(4 * i), 1'b0, 1'b0);
            step();
        end
        chk("full_count", 64'(Count), 64'd4);
        chk("full_ready", 64'(In_Ready), 64'd0);
        drive(1'b1, 32'h104, 32'h210, 1'b1, 1'b0);
        step();
        chk("pop_count", 64'(Count), 64'd3);
        chk("pop_ready", 64'(In_Ready), 64'd1);
        chk("pop_ir", 64'(Imm_number), 64'h0100);
        drive(1'b1, 32'h104, 32'h210, 1'b0, 1'b0);
        step();
        chk("fifth_count", 64'(Count), 64'd4);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        repeat (5) step();
        chk("starve_valid", 64'(IR_Valid), 64'd0);
        chk("starve_hold", 64'(Imm_number), 64'h0104);

        // Wrap and order: words 1..A with random concurrent loads.
        begin
            int n = 1;
            int seen = 0;
            int guard = 0;
            while (seen < 10 && guard < 200) begin
                drive(n <= 10 ? 1'b1 : 1'b0, 32'(n), 32'h1000 + 32'(4 * n),
                      1'($urandom_range(0, 1)), 1'b0);
                if (In_Valid && In_Ready) n++;
                step();
                if (IRWre && IR_Valid) begin
                    seen++;
                    chk("order", 64'(Imm_number), 64'(seen));
                    chk("order_pc", 64'(IR_PC), 64'h1000 + 64'(4 * seen));
                end
                guard++;
            end
            chk("order_done", 64'(seen), 64'd10);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        chk("empty_valid", 64'(IR_Valid), 64'd0);
        chk("empty_hold", 64'(Imm_number), 64'h000A);

        // Flush with concurrent push and load.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h300 + 32'(i), 32'h300, 1'b0, 1'b0);
            step();
        end
        chk("pre_flush", 64'(Count), 64'd3);
        drive(1'b1, 32'hDEAD, 32'h400, 1'b1, 1'b1);
        step();
        chk("flush_count", 64'(Count), 64'd0);
        chk("flush_valid", 64'(IR_Valid), 64'd0);
        drive(1'b1, 32'h555, 32'h500, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        chk("post_flush", 64'(Imm_number), 64'h0555);

`ifdef IR_EXT_IMM_EN
        drive(1'b1, 32'h0000_8000, 32'h600, 1'b0, 1'b0);
        step();
        step();
        ExtSel = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        chk("ext_sign", 64'(Ext_Imm), 64'hFFFF_8000);
        ExtSel = 1'b0;
        step();
        chk("ext_zero", 64'(Ext_Imm), 64'h0000_8000);
`endif

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));
`ifdef IR_EXT_IMM_EN
            ExtSel = 1'($urandom_range(0, 1));
`endif
            step();
        end

        // Asynchronous reset mid-cycle with data in flight.
        drive(1'b1, 32'hABCD_EF01, 32'h700, 1'b0, 1'b0);
        step();
        step();
        drive(1'b1, 32'h1, 32'h2, 1'b1, 1'b0);
        step();
        #3 RST_n = 1'b0;
        #1;
        model_reset();
        chk("arst_count", 64'(Count), 64'd0);
        chk("arst_ready", 64'(In_Ready), 64'd1);
        chk("arst_valid", 64'(IR_Valid), 64'd0);
        chk("arst_op", 64'(Op_code), 64'd0);
        chk("arst_rs", 64'(Rs_reg), 64'd0);
        chk("arst_rt", 64'(Rt_reg), 64'd0);
        chk("arst_imm", 64'(Imm_number), 64'd0);
        chk("arst_pc", 64'(IR_PC), 64'd0);
        drive(1'b1, 32'h2468_ACE0, 32'h800, 1'b0, 1'b0);
        @(negedge CLK);
        RST_n = 1'b1;
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        chk("first_after_rst", 64'(Imm_number), 64'hACE0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ir_prefetch_queue.md
Name: ir_prefetch_queue

Overview:
- Instruction register with a parametrised prefetch FIFO for the multi-cycle CPU.
- Sits between instruction memory and the control/decode stage.
- Buffers up to DEPTH fetched instructions, each with its PC, under a valid/ready handshake.
- On IRWre, loads the head entry into the decode register and splits it into MIPS fields.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- PC_W, 32, width of the PC stored alongside each instruction.
- CNT_W, $clog2(DEPTH)+1, width of Count (derived; do not override).

Ports:
- CLK  in  1  system clock, rising edge.
- RST_n  in  1  asynchronous active-low reset.
- Flush  in  1  discard FIFO contents and invalidate IR (branch/jump redirect).
- In_Valid  in  1  Ins_Data/Ins_PC valid from instruction memory.
- In_Ready  out  1  queue can accept a word.
- Ins_Data  in  32  fetched instruction.
- Ins_PC  in  PC_W  address of Ins_Data.
- IRWre  in  1  advance: load head entry into IR.
- Op_code  out  6  IR[31:26].
- Rs_reg  out  5  IR[25:21].
- Rt_reg  out  5  IR[20:16].
- Rd_reg  out  5  IR[15:11].
- Sa_number  out  5  IR[10:6].
- Imm_number  out  16  IR[15:0].
- IR_PC  out  PC_W  PC of instruction held in IR.
- IR_Valid  out  1  IR holds a live instruction.
- Count  out  CNT_W  FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (RST_n=0, asynchronous):
  - Read/write pointers and Count go to 0.
  - Op_code, Rs_reg, Rt_reg, Rd_reg, Sa_number, Imm_number, IR_PC all go to 0; IR_Valid goes to 0.
  - FIFO storage is not reset.
  - Effect is immediate, including mid-transfer. First push is accepted on the first rising edge after RST_n rises.
- In_Ready:
  - Combinational: In_Ready = (Count < DEPTH).
  - No full-with-pop bypass; In_Ready is 0 whenever Count = DEPTH.
- Push: on a rising edge with In_Valid & In_Ready, write {Ins_PC, Ins_Data} at the write pointer, then increment the write pointer modulo DEPTH.
- Pop/load: on a rising edge with IRWre and Count > 0:
  - Load the head entry into IR and IR_PC; set IR_Valid = 1.
  - Increment the read pointer modulo DEPTH.
- IRWre with Count = 0: IR_Valid <= 0; field outputs and IR_PC hold their previous values.
- IRWre = 0: IR, IR_PC and IR_Valid hold.
- Simultaneous push and pop: both take effect; Count is unchanged.
- No empty bypass: a word pushed at edge N reaches IR at edge N+1 at the earliest. Minimum latency from accept to IR is 1 cycle.
- Fields: pure slices of the registered IR. Imm_number overlaps Rd_reg/Sa_number by design.
- Flush (synchronous, highest priority over push and pop):
  - Pointers and Count go to 0; IR_Valid goes to 0; fields hold.
  - A push or IRWre in the same cycle is discarded.
- Count: always equals (wr_ptr − rd_ptr) mod 2·DEPTH. Never exceeds DEPTH and never underflows.

Optional Feature:
- Macro: IR_EXT_IMM_EN.
- When defined:
  - Adds input ExtSel (1 bit) and output Ext_Imm (32 bits).
  - Ext_Imm is registered on the same IR load as the fields: sign-extended head[15:0] when ExtSel=1, zero-extended when ExtSel=0.
  - Ext_Imm resets to 0 and holds when no load occurs.
- When undefined: neither port exists; behaviour is otherwise identical.

Test Plan:
- Reset: RST_n=0 asynchronously mid-cycle → all outputs 0 before the next edge; In_Ready=1, Count=0, IR_Valid=0.
- Decode: push 32'h8C221234 with PC 32'h10, IRWre next cycle → Op_code=6'h23, Rs_reg=1, Rt_reg=2, Rd_reg=2, Sa_number=8, Imm_number=16'h1234, IR_PC=32'h10, IR_Valid=1, Count=0.
- Full: DEPTH=4, IRWre=0, five back-to-back In_Valid → 4 accepted, Count=4, In_Ready=0, 5th word held. One IRWre → Count=3, In_Ready=1, 5th word accepted on the following edge.
- Wrap and order: 10 words 32'h1..32'hA pushed with concurrent and interleaved IRWre → IR sequence exactly 1..A, IR_PC matches each word. IRWre while empty → IR_Valid=0, fields hold last value.
- Flush: Count=3, In_Valid=1, IRWre=1, Flush=1 on the same edge → Count=0, IR_Valid=0, pushed word absent from later pops.
- IR_EXT_IMM_EN: Imm 16'h8000 with ExtSel=1 → Ext_Imm=32'hFFFF8000; ExtSel=0 → 32'h00008000.
